// File: rtl/uart_cmd_ctrl_if.sv
// Handshake and bus bundle for uart_cmd_ctrl: UART receive/transmit byte streams and the register bus.
// The master modport is the sequencer's view; the slave modport is the view of the cores around it.
interface uart_cmd_ctrl_if;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       tx_busy;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       pkt_err;

  modport master (
    input  rx_vld, rx_data, rx_perr, reg_rdata, reg_ack, tx_busy,
    output reg_wr, reg_rd, reg_addr, reg_wdata, tx_req, tx_data, pkt_err
  );

  modport slave (
    output rx_vld, rx_data, rx_perr, reg_rdata, reg_ack, tx_busy,
    input  reg_wr, reg_rd, reg_addr, reg_wdata, tx_req, tx_data, pkt_err
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Serial command sequencer: assembles CMD/ADDR/DATA/TRL packets, issues one register access, returns one response byte.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 2000
) (
  input logic             clk,
  input logic             rst,
  uart_cmd_ctrl_if.master bus
);

  localparam logic [7:0] CMD_WR  = 8'h20;
  localparam logic [7:0] CMD_RD  = 8'h21;
  localparam logic [7:0] TRAILER = 8'hAA;
  localparam logic [7:0] WR_RESP = 8'h55;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("uart_cmd_ctrl: TIMEOUT_CYC must lie in 2..65535");
  end

  typedef enum logic [2:0] {
    S_CMD, S_ADR, S_DAT, S_TRL, S_EXE, S_RDW, S_TX
  } state_t;

  state_t     r_state;
  logic       r_is_rd;
  logic       r_reg_wr;
  logic       r_reg_rd;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_wdata;
  logic       r_tx_req;
  logic [7:0] r_tx_data;
  logic       r_pkt_err;

  logic w_cmd_ok;
  logic w_trl_ok;
  logic w_timeout;

  assign w_cmd_ok = !bus.rx_perr && (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD);
  assign w_trl_ok = !bus.rx_perr && (bus.rx_data == TRAILER);

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] r_tocnt;
  logic        w_in_pkt;

  assign w_in_pkt  = (r_state == S_ADR) || (r_state == S_DAT) || (r_state == S_TRL);
  assign w_timeout = w_in_pkt && !bus.rx_vld && (r_tocnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Strobes default low each cycle; responses are issued one cycle after tx_busy is seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CMD;
      r_is_rd     <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_reg_addr  <= 8'h00;
      r_reg_wdata <= 8'h00;
      r_tx_req    <= 1'b0;
      r_tx_data   <= 8'h00;
      r_pkt_err   <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      r_tocnt     <= 16'h0000;
`endif
    end else begin
      r_reg_wr  <= 1'b0;
      r_reg_rd  <= 1'b0;
      r_tx_req  <= 1'b0;
      r_pkt_err <= 1'b0;

      case (r_state)
        S_CMD: begin
          if (bus.rx_vld) begin
            if (w_cmd_ok) begin
              r_is_rd <= bus.rx_data[0];
              r_state <= S_ADR;
            end else begin
              r_pkt_err <= 1'b1;
            end
          end
        end
        S_ADR: begin
          if (bus.rx_vld) begin
            if (bus.rx_perr) begin
              r_pkt_err <= 1'b1;
              r_state   <= S_CMD;
            end else begin
              r_reg_addr <= bus.rx_data;
              r_state    <= S_DAT;
            end
          end else if (w_timeout) begin
            r_pkt_err <= 1'b1;
            r_state   <= S_CMD;
          end
        end
        S_DAT: begin
          if (bus.rx_vld) begin
            if (bus.rx_perr) begin
              r_pkt_err <= 1'b1;
              r_state   <= S_CMD;
            end else begin
              r_reg_wdata <= bus.rx_data;
              r_state     <= S_TRL;
            end
          end else if (w_timeout) begin
            r_pkt_err <= 1'b1;
            r_state   <= S_CMD;
          end
        end
        // The access strobe is launched here so it appears the cycle right after the trailer.
        S_TRL: begin
          if (bus.rx_vld) begin
            if (w_trl_ok) begin
              r_reg_wr <= !r_is_rd;
              r_reg_rd <= r_is_rd;
              r_state  <= S_EXE;
            end else begin
              r_pkt_err <= 1'b1;
              r_state   <= S_CMD;
            end
          end else if (w_timeout) begin
            r_pkt_err <= 1'b1;
            r_state   <= S_CMD;
          end
        end
        S_EXE: begin
          if (bus.rx_vld) r_pkt_err <= 1'b1;
          if (r_is_rd) begin
            r_state <= S_RDW;
          end else begin
            r_tx_data <= WR_RESP;
            if (!bus.tx_busy) begin
              r_tx_req <= 1'b1;
              r_state  <= S_CMD;
            end else begin
              r_state <= S_TX;
            end
          end
        end
        S_RDW: begin
          if (bus.rx_vld) r_pkt_err <= 1'b1;
          if (bus.reg_ack) begin
            r_tx_data <= bus.reg_rdata;
            if (!bus.tx_busy) begin
              r_tx_req <= 1'b1;
              r_state  <= S_CMD;
            end else begin
              r_state <= S_TX;
            end
          end
        end
        S_TX: begin
          if (bus.rx_vld) r_pkt_err <= 1'b1;
          if (!bus.tx_busy) begin
            r_tx_req <= 1'b1;
            r_state  <= S_CMD;
          end
        end
        default: r_state <= S_CMD;
      endcase

`ifdef UART_CMD_TIMEOUT_EN
      if (w_in_pkt && !bus.rx_vld && !w_timeout) r_tocnt <= r_tocnt + 16'd1;
      else                                       r_tocnt <= 16'h0000;
`endif
    end
  end

  assign bus.reg_wr    = r_reg_wr;
  assign bus.reg_rd    = r_reg_rd;
  assign bus.reg_addr  = r_reg_addr;
  assign bus.reg_wdata = r_reg_wdata;
  assign bus.tx_req    = r_tx_req;
  assign bus.tx_data   = r_tx_data;
  assign bus.pkt_err   = r_pkt_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected strobes (with their cycle) are queued as stimulus is driven.
// Honours UART_CMD_TIMEOUT_EN for the timeout scenario.
module tb_uart_cmd_ctrl;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } ev_t;

  ev_t wrQ[$];
  ev_t rdQ[$];
  ev_t txQ[$];
  int  errQ[$];

  // Every strobe the DUT raises must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  ec;
    if (!rst) begin
      if (bus.reg_wr === 1'b1) begin
        checks++;
        if (wrQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL reg_wr unexpected: addr=%h data=%h cycle=%0d, none expected", bus.reg_addr, bus.reg_wdata, cyc);
        end else begin
          e = wrQ.pop_front();
          if (bus.reg_addr !== e.a || bus.reg_wdata !== e.d || cyc != e.c) begin
            errors++;
            $display("[TB] FAIL reg_wr: got addr=%h data=%h cycle=%0d, want addr=%h data=%h cycle=%0d", bus.reg_addr, bus.reg_wdata, cyc, e.a, e.d, e.c);
          end
        end
      end
      if (bus.reg_rd === 1'b1) begin
        checks++;
        if (rdQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL reg_rd unexpected: addr=%h cycle=%0d, none expected", bus.reg_addr, cyc);
        end else begin
          e = rdQ.pop_front();
          if (bus.reg_addr !== e.a || cyc != e.c) begin
            errors++;
            $display("[TB] FAIL reg_rd: got addr=%h cycle=%0d, want addr=%h cycle=%0d", bus.reg_addr, cyc, e.a, e.c);
          end
        end
      end
      if (bus.tx_req === 1'b1) begin
        checks++;
        if (txQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL tx_req unexpected: data=%h cycle=%0d, none expected", bus.tx_data, cyc);
        end else begin
          e = txQ.pop_front();
          if (bus.tx_data !== e.d || cyc != e.c) begin
            errors++;
            $display("[TB] FAIL tx_req: got data=%h cycle=%0d, want data=%h cycle=%0d", bus.tx_data, cyc, e.d, e.c);
          end
        end
      end
      if (bus.pkt_err === 1'b1) begin
        checks++;
        if (errQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL pkt_err unexpected at cycle=%0d, none expected", cyc);
        end else begin
          ec = errQ.pop_front();
          if (cyc != ec) begin
            errors++;
            $display("[TB] FAIL pkt_err: got cycle=%0d, want cycle=%0d", cyc, ec);
          end
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic perr, output int c);
    @(posedge clk);
    #1;
    bus.rx_vld  = 1'b1;
    bus.rx_data = b;
    bus.rx_perr = perr;
    c = cyc;
    @(posedge clk);
    #1;
    bus.rx_vld  = 1'b0;
    bus.rx_perr = 1'b0;
  endtask

  task automatic sendPacket(input logic [7:0] cmd, input logic [7:0] adr, input logic [7:0] dat,
                            input logic [7:0] trl, output int c);
    int t;
    sendByte(cmd, 1'b0, t);
    sendByte(adr, 1'b0, t);
    sendByte(dat, 1'b0, t);
    sendByte(trl, 1'b0, c);
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.reg_wr, bus.reg_rd, bus.tx_req, bus.pkt_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b, want 0000", {bus.reg_wr, bus.reg_rd, bus.tx_req, bus.pkt_err});
    end
    checks++;
    if (bus.reg_addr !== 8'h00 || bus.reg_wdata !== 8'h00 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h tx=%h, want 00 00 00", bus.reg_addr, bus.reg_wdata, bus.tx_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_write();
    int c;
    sendPacket(8'h20, 8'h00, 8'h85, 8'hAA, c);
    wrQ.push_back('{8'h00, 8'h85, c + 1});
    txQ.push_back('{8'h00, 8'h55, c + 2});
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (wrQ.size() + txQ.size() + errQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL write_drain: pending=%0d, want 0", wrQ.size() + txQ.size() + errQ.size());
    end
    checks++;
    if (bus.reg_addr !== 8'h00 || bus.reg_wdata !== 8'h85) begin
      errors++;
      $display("[TB] FAIL write_hold: got addr=%h wdata=%h, want 00 85", bus.reg_addr, bus.reg_wdata);
    end
  endtask

  task automatic test_read();
    int c;
    int b;
    sendPacket(8'h21, 8'h10, 8'h00, 8'hAA, c);
    rdQ.push_back('{8'h10, 8'h00, c + 1});
    repeat (3) @(posedge clk);
    #1;
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 8'h3C;
    bus.tx_busy   = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_ack   = 1'b0;
    bus.reg_rdata = 8'hFF;
    repeat (9) @(posedge clk);
    #1;
    bus.tx_busy = 1'b0;
    b = cyc;
    txQ.push_back('{8'h00, 8'h3C, b + 1});
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rdQ.size() + txQ.size() + errQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL read_drain: pending=%0d, want 0", rdQ.size() + txQ.size() + errQ.size());
    end
    checks++;
    if (bus.reg_addr !== 8'h10) begin
      errors++;
      $display("[TB] FAIL read_hold: got addr=%h, want 10", bus.reg_addr);
    end
  endtask

  task automatic test_bad_framing();
    int c;
    sendByte(8'h47, 1'b0, c);
    errQ.push_back(c + 1);
    sendPacket(8'h20, 8'h01, 8'h02, 8'hAB, c);
    errQ.push_back(c + 1);
    sendPacket(8'h20, 8'h33, 8'hC4, 8'hAA, c);
    wrQ.push_back('{8'h33, 8'hC4, c + 1});
    txQ.push_back('{8'h00, 8'h55, c + 2});
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (wrQ.size() + txQ.size() + errQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL framing_drain: pending=%0d, want 0", wrQ.size() + txQ.size() + errQ.size());
    end
  endtask

  task automatic test_parity();
    int c;
    sendByte(8'h20, 1'b0, c);
    sendByte(8'h05, 1'b0, c);
    sendByte(8'h77, 1'b1, c);
    errQ.push_back(c + 1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.reg_wdata === 8'h77) begin
      errors++;
      $display("[TB] FAIL parity_latch: got wdata=%h, want not 77", bus.reg_wdata);
    end
    sendPacket(8'h20, 8'h05, 8'h77, 8'hAA, c);
    wrQ.push_back('{8'h05, 8'h77, c + 1});
    txQ.push_back('{8'h00, 8'h55, c + 2});
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (wrQ.size() + txQ.size() + errQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL parity_drain: pending=%0d, want 0", wrQ.size() + txQ.size() + errQ.size());
    end
  endtask

  task automatic test_timeout();
    int c;
    sendByte(8'h20, 1'b0, c);
    sendByte(8'h00, 1'b0, c);
`ifdef UART_CMD_TIMEOUT_EN
    errQ.push_back(c + TO + 1);
`endif
    repeat (55) @(posedge clk);
    sendByte(8'h85, 1'b0, c);
`ifdef UART_CMD_TIMEOUT_EN
    errQ.push_back(c + 1);
`endif
    sendByte(8'hAA, 1'b0, c);
`ifdef UART_CMD_TIMEOUT_EN
    errQ.push_back(c + 1);
`else
    wrQ.push_back('{8'h00, 8'h85, c + 1});
    txQ.push_back('{8'h00, 8'h55, c + 2});
`endif
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (wrQ.size() + txQ.size() + errQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL timeout_drain: pending=%0d, want 0", wrQ.size() + txQ.size() + errQ.size());
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int b;
    bus.tx_busy = 1'b1;
    sendPacket(8'h20, 8'h01, 8'h11, 8'hAA, c);
    wrQ.push_back('{8'h01, 8'h11, c + 1});
    sendByte(8'h5A, 1'b0, c);
    errQ.push_back(c + 1);
    @(posedge clk);
    #1;
    bus.tx_busy = 1'b0;
    b = cyc;
    txQ.push_back('{8'h00, 8'h55, b + 1});
    sendPacket(8'h21, 8'h02, 8'h00, 8'hAA, c);
    rdQ.push_back('{8'h02, 8'h00, c + 1});
    repeat (2) @(posedge clk);
    #1;
    bus.rx_vld    = 1'b1;
    bus.rx_data   = 8'h99;
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 8'hE7;
    c = cyc;
    errQ.push_back(c + 1);
    txQ.push_back('{8'h00, 8'hE7, c + 1});
    @(posedge clk);
    #1;
    bus.rx_vld  = 1'b0;
    bus.reg_ack = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (wrQ.size() + rdQ.size() + txQ.size() + errQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: pending=%0d, want 0", wrQ.size() + rdQ.size() + txQ.size() + errQ.size());
    end
  endtask

  task automatic test_reset_mid_read();
    int c;
    sendPacket(8'h21, 8'h44, 8'h00, 8'hAA, c);
    rdQ.push_back('{8'h44, 8'h00, c + 1});
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.reg_wr, bus.reg_rd, bus.tx_req, bus.pkt_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrd_strobes: got %b, want 0000", {bus.reg_wr, bus.reg_rd, bus.tx_req, bus.pkt_err});
    end
    checks++;
    if (bus.reg_addr !== 8'h00 || bus.reg_wdata !== 8'h00 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrd_data: got addr=%h wdata=%h tx=%h, want 00 00 00", bus.reg_addr, bus.reg_wdata, bus.tx_data);
    end
    @(posedge clk);
    #1;
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 8'h5C;
    @(posedge clk);
    #1 bus.reg_ack = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rdQ.size() + txQ.size() + errQ.size() != 0 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrd_drain: pending=%0d tx=%h, want 0 and 00", rdQ.size() + txQ.size() + errQ.size(), bus.tx_data);
    end
  endtask

  initial begin
    bus.rx_vld    = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_perr   = 1'b0;
    bus.reg_rdata = 8'h00;
    bus.reg_ack   = 1'b0;
    bus.tx_busy   = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_bad_framing();
    test_parity();
    test_timeout();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
